// File: rtl/urv_io_responder.sv
// Memory-mapped I/O target on the urv_cpu data bus. It provides a GPIO register,
// a baud divisor, and an 8N1 UART transmitter fed by a small FIFO.
module urv_io_responder #(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_store_i,
  input  logic        dm_load_i,
  output logic [31:0] dm_data_l_o,
  output logic        dm_store_done_o,
  output logic        dm_load_done_o,
  output logic        dm_ready_o,
  output logic        io_sel_o,
  output logic [7:0]  gpio_o,
  output logic        uart_tx_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

  logic [7:0]    gpio;
  logic [15:0]   div;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          pend;
  logic [7:0]    pend_byte;
  logic [31:0]   load_data;
  logic          load_done, store_done;

  tx_state_t     state, state_n;
  logic [15:0]   cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;

  logic [7:0]    offset;
  logic          accept, fifo_full, fifo_empty, tx_busy;
  logic          tx_store, push_new, push_pend, stall, push, pop;
  logic [7:0]    push_byte;
  logic [2:0]    count3;
  logic [31:0]   rd_data;
  logic          unused_bits;

  assign io_sel_o    = (dm_addr_i[31:8] == 24'h100000);
  assign offset      = dm_addr_i[7:0];
  assign accept      = io_sel_o && (dm_load_i || dm_store_i) && !pend;
  assign fifo_full   = (count == CW'(FIFO_DEPTH));
  assign fifo_empty  = (count == '0);
  assign tx_busy     = (state != S_IDLE);
  assign count3      = 3'(count);
  assign unused_bits = ^{dm_data_s_i[31:16], dm_data_select_i[3:2]};

  assign tx_store  = accept && dm_store_i && (offset == 8'h04) && dm_data_select_i[0];
  assign push_new  = tx_store && !fifo_full;
  assign stall     = tx_store && fifo_full;
  assign push_pend = pend && !fifo_full;
  assign push      = push_new || push_pend;
  assign push_byte = pend ? pend_byte : dm_data_s_i[7:0];

  always_comb begin
    rd_data = '0;
    case (offset)
      8'h00:   rd_data = {24'd0, gpio};
      8'h08:   rd_data = {26'd0, count3, fifo_empty, fifo_full, tx_busy};
      8'h0C:   rd_data = {16'd0, div};
      default: rd_data = '0;
    endcase
  end

  // Load+store together is handled as a store; the load side completes with zero data.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      gpio       <= '0;
      div        <= DEFAULT_DIV;
      pend       <= 1'b0;
      pend_byte  <= '0;
      load_data  <= '0;
      load_done  <= 1'b0;
      store_done <= 1'b0;
    end else begin
      load_done  <= 1'b0;
      store_done <= 1'b0;
      if (accept) begin
        if (dm_store_i) begin
          if (offset == 8'h00 && dm_data_select_i[0]) gpio <= dm_data_s_i[7:0];
          if (offset == 8'h0C) begin
            if (dm_data_select_i[0]) div[7:0]  <= dm_data_s_i[7:0];
            if (dm_data_select_i[1]) div[15:8] <= dm_data_s_i[15:8];
          end
          if (stall) begin
            pend      <= 1'b1;
            pend_byte <= dm_data_s_i[7:0];
          end else begin
            store_done <= 1'b1;
          end
          if (dm_load_i) begin
            load_done <= 1'b1;
            load_data <= '0;
          end
        end else begin
          load_done <= 1'b1;
          load_data <= rd_data;
        end
      end
      if (push_pend) begin
        pend       <= 1'b0;
        store_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= push_byte;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
    end
  end

  // STOP chains straight into START when another byte is queued, so frames abut.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = S_START;
          cnt_n   = div;
          shreg_n = mem[rptr];
        end
      end
      S_START: begin
        if (cnt != 16'd0) begin
          cnt_n = cnt - 16'd1;
        end else begin
          state_n   = S_DATA;
          cnt_n     = div;
          bit_idx_n = '0;
        end
      end
      S_DATA: begin
        if (cnt != 16'd0) begin
          cnt_n = cnt - 16'd1;
        end else begin
          cnt_n = div;
          if (bit_idx == 3'd7) begin
            state_n = S_STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            shreg_n   = {1'b0, shreg[7:1]};
          end
        end
      end
      S_STOP: begin
        if (cnt != 16'd0) begin
          cnt_n = cnt - 16'd1;
        end else if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = S_START;
          cnt_n   = div;
          shreg_n = mem[rptr];
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    uart_tx_o = 1'b1;
    case (state)
      S_START: uart_tx_o = 1'b0;
      S_DATA:  uart_tx_o = shreg[0];
      default: uart_tx_o = 1'b1;
    endcase
  end

  assign dm_data_l_o     = load_data;
  assign dm_load_done_o  = load_done;
  assign dm_store_done_o = store_done;
  assign dm_ready_o      = !pend;
  assign gpio_o          = gpio;

endmodule

// File: tb/tb_urv_io_responder.sv
// Directed bench for urv_io_responder: register access, UART framing,
// FIFO backpressure and reset behaviour.
module tb_urv_io_responder;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] dm_addr_i = '0;
  logic [31:0] dm_data_s_i = '0;
  logic [3:0]  dm_data_select_i = '0;
  logic        dm_store_i = 1'b0;
  logic        dm_load_i = 1'b0;
  logic [31:0] dm_data_l_o;
  logic        dm_store_done_o, dm_load_done_o, dm_ready_o, io_sel_o, uart_tx_o;
  logic [7:0]  gpio_o;

  int total = 0;
  int bad = 0;

  localparam logic [31:0] A_GPIO = 32'h1000_0000;
  localparam logic [31:0] A_TX   = 32'h1000_0004;
  localparam logic [31:0] A_STAT = 32'h1000_0008;
  localparam logic [31:0] A_DIV  = 32'h1000_000C;

  urv_io_responder #(.FIFO_DEPTH(4), .DEFAULT_DIV(16'd433)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .dm_addr_i(dm_addr_i), .dm_data_s_i(dm_data_s_i),
    .dm_data_select_i(dm_data_select_i), .dm_store_i(dm_store_i), .dm_load_i(dm_load_i),
    .dm_data_l_o(dm_data_l_o), .dm_store_done_o(dm_store_done_o),
    .dm_load_done_o(dm_load_done_o), .dm_ready_o(dm_ready_o), .io_sel_o(io_sel_o),
    .gpio_o(gpio_o), .uart_tx_o(uart_tx_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic fbit(input logic [7:0] b, input int p);
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return b[p-1];
  endfunction

  task automatic bus_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel,
                           input logic with_load, output logic ds, output logic dl,
                           output logic [31:0] ld);
    @(negedge clk_i);
    dm_addr_i = a; dm_data_s_i = d; dm_data_select_i = sel;
    dm_store_i = 1'b1; dm_load_i = with_load;
    @(negedge clk_i);
    ds = dm_store_done_o; dl = dm_load_done_o; ld = dm_data_l_o;
    dm_store_i = 1'b0; dm_load_i = 1'b0;
  endtask

  task automatic bus_load(input logic [31:0] a, output logic [31:0] d, output logic dl);
    @(negedge clk_i);
    dm_addr_i = a; dm_load_i = 1'b1;
    @(negedge clk_i);
    d = dm_data_l_o; dl = dm_load_done_o;
    dm_load_i = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d; logic dl;
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    total++; if (gpio_o !== 8'h00) begin bad++; $display("FAIL rst_gpio got=%h exp=00", gpio_o); end
    total++; if (uart_tx_o !== 1'b1) begin bad++; $display("FAIL rst_tx got=%b exp=1", uart_tx_o); end
    total++; if (dm_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", dm_ready_o); end
    total++; if ({dm_store_done_o, dm_load_done_o} !== 2'b00) begin bad++; $display("FAIL rst_done got=%b exp=00", {dm_store_done_o, dm_load_done_o}); end
    rst_i = 1'b1;
    bus_load(A_STAT, d, dl);
    total++; if (d !== 32'h0000_0004) begin bad++; $display("FAIL rst_status got=%h exp=00000004", d); end
    total++; if (dl !== 1'b1) begin bad++; $display("FAIL rst_load_done got=%b exp=1", dl); end
    @(negedge clk_i);
    total++; if (dm_load_done_o !== 1'b0) begin bad++; $display("FAIL load_done_pulse got=%b exp=0", dm_load_done_o); end
    total++; if (dm_data_l_o !== 32'h0000_0004) begin bad++; $display("FAIL load_data_hold got=%h exp=00000004", dm_data_l_o); end
  endtask

  task automatic test_gpio;
    logic ds, dl; logic [31:0] ld, d;
    bus_store(A_GPIO, 32'hFFFF_FFA5, 4'b0001, 1'b0, ds, dl, ld);
    total++; if (ds !== 1'b1) begin bad++; $display("FAIL gpio_store_done got=%b exp=1", ds); end
    total++; if (gpio_o !== 8'hA5) begin bad++; $display("FAIL gpio_val got=%h exp=a5", gpio_o); end
    bus_store(A_GPIO, 32'h0000_005A, 4'b1110, 1'b0, ds, dl, ld);
    total++; if (gpio_o !== 8'hA5) begin bad++; $display("FAIL gpio_lane_mask got=%h exp=a5", gpio_o); end
    total++; if (ds !== 1'b1) begin bad++; $display("FAIL gpio_masked_done got=%b exp=1", ds); end
    bus_load(A_GPIO, d, dl);
    total++; if (d !== 32'h0000_00A5) begin bad++; $display("FAIL gpio_read got=%h exp=000000a5", d); end
  endtask

  task automatic test_div_lanes;
    logic ds, dl; logic [31:0] ld, d;
    bus_load(A_DIV, d, dl);
    total++; if (d !== 32'h0000_01B1) begin bad++; $display("FAIL div_default got=%h exp=000001b1", d); end
    bus_store(A_DIV, 32'h0000_1234, 4'b0001, 1'b0, ds, dl, ld);
    bus_load(A_DIV, d, dl);
    total++; if (d !== 32'h0000_0134) begin bad++; $display("FAIL div_lane0 got=%h exp=00000134", d); end
    bus_store(A_DIV, 32'h0000_5600, 4'b0010, 1'b0, ds, dl, ld);
    bus_load(A_DIV, d, dl);
    total++; if (d !== 32'h0000_5634) begin bad++; $display("FAIL div_lane1 got=%h exp=00005634", d); end
  endtask

  task automatic test_misc;
    logic ds, dl; logic [31:0] ld, d;
    bus_load(32'h1000_0010, d, dl);
    total++; if (d !== 32'h0 || dl !== 1'b1) begin bad++; $display("FAIL unmapped_load got=%h/%b exp=00000000/1", d, dl); end
    bus_store(32'h1000_0020, 32'hFFFF_FFFF, 4'b1111, 1'b0, ds, dl, ld);
    total++; if (ds !== 1'b1) begin bad++; $display("FAIL unmapped_store_done got=%b exp=1", ds); end
    total++; if (gpio_o !== 8'hA5) begin bad++; $display("FAIL unmapped_store_effect got=%h exp=a5", gpio_o); end
    bus_store(A_TX, 32'h0000_0077, 4'b0010, 1'b0, ds, dl, ld);
    total++; if (ds !== 1'b1) begin bad++; $display("FAIL tx_nolane_done got=%b exp=1", ds); end
    bus_load(A_STAT, d, dl);
    total++; if (d !== 32'h0000_0004) begin bad++; $display("FAIL tx_nolane_status got=%h exp=00000004", d); end
    bus_load(A_TX, d, dl);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL txdata_read got=%h exp=00000000", d); end
    bus_store(A_GPIO, 32'h0000_003C, 4'b0001, 1'b1, ds, dl, ld);
    total++; if ({ds, dl} !== 2'b11) begin bad++; $display("FAIL both_done got=%b exp=11", {ds, dl}); end
    total++; if (ld !== 32'h0) begin bad++; $display("FAIL both_data got=%h exp=00000000", ld); end
    total++; if (gpio_o !== 8'h3C) begin bad++; $display("FAIL both_gpio got=%h exp=3c", gpio_o); end
    @(negedge clk_i);
    dm_addr_i = 32'h2000_0004; #1;
    total++; if (io_sel_o !== 1'b0) begin bad++; $display("FAIL io_sel_off got=%b exp=0", io_sel_o); end
    dm_addr_i = 32'h1000_00F0; #1;
    total++; if (io_sel_o !== 1'b1) begin bad++; $display("FAIL io_sel_on got=%b exp=1", io_sel_o); end
    bus_load(32'h2000_0008, d, dl);
    total++; if (dl !== 1'b0) begin bad++; $display("FAIL foreign_load_done got=%b exp=0", dl); end
  endtask

  task automatic test_uart_frame;
    logic ds, dl; logic [31:0] ld;
    bus_store(A_DIV, 32'h0000_0003, 4'b0011, 1'b0, ds, dl, ld);
    bus_store(A_TX, 32'h0000_0055, 4'b0001, 1'b0, ds, dl, ld);
    total++; if (ds !== 1'b1) begin bad++; $display("FAIL frame_store_done got=%b exp=1", ds); end
    total++; if (uart_tx_o !== 1'b1) begin bad++; $display("FAIL frame_pre_idle got=%b exp=1", uart_tx_o); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      total++;
      if (uart_tx_o !== fbit(8'h55, i / 4)) begin
        bad++; $display("FAIL frame_bit i=%0d got=%b exp=%b", i, uart_tx_o, fbit(8'h55, i / 4));
      end
    end
    @(negedge clk_i);
    total++; if (uart_tx_o !== 1'b1) begin bad++; $display("FAIL frame_post_idle got=%b exp=1", uart_tx_o); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [6];
    logic [31:0] d; logic dl; int idx;
    bytes = '{8'h31, 8'hC4, 8'h0F, 8'hA2, 8'h7E, 8'h99};
    @(negedge clk_i);
    dm_addr_i = A_TX; dm_data_s_i = {24'd0, bytes[0]}; dm_data_select_i = 4'b0001; dm_store_i = 1'b1;
    for (int k = 0; k <= 240; k++) begin
      @(negedge clk_i);
      if (k <= 4) begin
        total++; if (dm_store_done_o !== 1'b1) begin bad++; $display("FAIL b2b_done k=%0d got=%b exp=1", k, dm_store_done_o); end
      end else if (k <= 41) begin
        total++; if ({dm_store_done_o, dm_ready_o} !== 2'b00) begin bad++; $display("FAIL b2b_stall k=%0d got=%b exp=00", k, {dm_store_done_o, dm_ready_o}); end
      end else if (k == 42) begin
        total++; if ({dm_store_done_o, dm_ready_o} !== 2'b11) begin bad++; $display("FAIL b2b_release got=%b exp=11", {dm_store_done_o, dm_ready_o}); end
      end else if (k == 43) begin
        total++; if (dm_store_done_o !== 1'b0) begin bad++; $display("FAIL b2b_release_pulse got=%b exp=0", dm_store_done_o); end
      end
      if (k >= 1) begin
        idx = k - 1;
        total++;
        if (uart_tx_o !== fbit(bytes[idx / 40], (idx % 40) / 4)) begin
          bad++; $display("FAIL b2b_serial k=%0d got=%b exp=%b", k, uart_tx_o, fbit(bytes[idx / 40], (idx % 40) / 4));
        end
      end
      if (k < 5) dm_data_s_i = {24'd0, bytes[k + 1]};
      else dm_store_i = 1'b0;
    end
    bus_load(A_STAT, d, dl);
    total++; if (d !== 32'h0000_0004) begin bad++; $display("FAIL b2b_final_status got=%h exp=00000004", d); end
  endtask

  task automatic test_reset_mid_stall;
    logic [31:0] d; logic dl; logic seen;
    @(negedge clk_i);
    dm_addr_i = A_TX; dm_data_s_i = 32'h0000_0011; dm_data_select_i = 4'b0001; dm_store_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      if (k == 5) dm_store_i = 1'b0;
      else if (k < 5) dm_data_s_i = dm_data_s_i + 32'h11;
    end
    total++; if (dm_ready_o !== 1'b0) begin bad++; $display("FAIL stall_before_rst got=%b exp=0", dm_ready_o); end
    rst_i = 1'b0; #1;
    total++; if (dm_ready_o !== 1'b1) begin bad++; $display("FAIL rst_async_ready got=%b exp=1", dm_ready_o); end
    total++; if (uart_tx_o !== 1'b1) begin bad++; $display("FAIL rst_async_tx got=%b exp=1", uart_tx_o); end
    total++; if (gpio_o !== 8'h00) begin bad++; $display("FAIL rst_async_gpio got=%h exp=00", gpio_o); end
    seen = 1'b0;
    repeat (2) begin @(negedge clk_i); if (dm_store_done_o !== 1'b0) seen = 1'b1; end
    rst_i = 1'b1;
    repeat (50) begin @(negedge clk_i); if (dm_store_done_o !== 1'b0 || uart_tx_o !== 1'b1) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rst_stall_quiet got=%b exp=0", seen); end
    bus_load(A_STAT, d, dl);
    total++; if (d !== 32'h0000_0004) begin bad++; $display("FAIL rst_stall_status got=%h exp=00000004", d); end
  endtask

  initial begin
    test_reset();
    test_gpio();
    test_div_lanes();
    test_misc();
    test_uart_frame();
    test_back_to_back();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
